// File: rtl/polyphase_interp.sv
// Polyphase FIR interpolator: one input per symbol strobe, L filtered outputs per symbol.
// Products, a registered adder tree and a rounding/saturating output stage are fully pipelined.
module polyphase_interp #(
    parameter int L         = 4,
    parameter int TAPS      = 20,
    parameter int DW        = 18,
    parameter int CW        = 18,
    parameter int OUT_SHIFT = 17
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sam_clk_ena,
    input  logic                    sym_clk_ena,
    input  logic signed [DW-1:0]    x_in,
    input  logic                    coef_wr_en,
    input  logic [$clog2(TAPS)-1:0] coef_wr_addr,
    input  logic signed [CW-1:0]    coef_wr_data,
    output logic signed [DW-1:0]    y,
    output logic                    y_valid,
    output logic                    sat
);

    localparam int TPP = TAPS / L;
    localparam int LVL = $clog2(TPP);
    localparam int AW  = DW + CW + LVL;
    localparam int PW  = $clog2(L);
    localparam logic [PW-1:0]      PH_LAST = PW'(L - 1);
    localparam logic signed [AW:0] HALF    = ((AW+1)'(1) << OUT_SHIFT) >> 1;
    localparam logic signed [AW:0] YMAX    = (AW+1)'((64'sd1 <<< (DW-1)) - 64'sd1);
    localparam logic signed [AW:0] YMIN    = ~YMAX;

    // Number of live nodes at a given adder-tree level (odd leftovers pass through).
    function automatic int node_cnt(input int lv);
        int n;
        n = TPP;
        for (int j = 0; j < lv; j++) n = (n + 1) / 2;
        return n;
    endfunction

    function automatic logic signed [AW:0] round_fn(input logic signed [AW-1:0] a);
        logic signed [AW:0] t;
        t = (AW+1)'(a) + HALF;
        return t >>> OUT_SHIFT;
    endfunction

    function automatic logic [DW:0] sat_fn(input logic signed [AW:0] r);
        logic [DW:0] res;
        if (r > YMAX)      res = {1'b1, YMAX[DW-1:0]};
        else if (r < YMIN) res = {1'b1, YMIN[DW-1:0]};
        else               res = {1'b0, r[DW-1:0]};
        return res;
    endfunction

    logic signed [CW-1:0] c_q      [0:TAPS-1];
    logic signed [DW-1:0] xd_q     [0:TPP-1];
    logic signed [DW-1:0] xd_d     [0:TPP-1];
    logic signed [CW-1:0] coef_sel [0:TPP-1];
    logic signed [AW-1:0] tree_q   [0:LVL][0:TPP-1];
    logic signed [AW-1:0] tree_d   [0:LVL][0:TPP-1];
    logic [LVL:0]         vld_q;
    logic [PW-1:0]        phase_q, phase_d, phase_use;
    logic                 shift;
    logic signed [DW-1:0] y_q, y_d, y_c;
    logic                 y_valid_q, sat_q, sat_d, sat_c;

    assign shift     = sym_clk_ena & sam_clk_ena;
    assign phase_use = shift ? '0 : phase_q;

    always_comb begin
        phase_d = phase_q;
        if (sam_clk_ena) phase_d = (phase_use == PH_LAST) ? '0 : phase_use + PW'(1);
    end

    // The new sample must reach tap 0 in the same strobe, so products use the shifted line.
    always_comb begin
        xd_d = xd_q;
        if (shift) begin
            xd_d[0] = x_in;
            for (int k = 1; k < TPP; k++) xd_d[k] = xd_q[k-1];
        end
        for (int k = 0; k < TPP; k++) coef_sel[k] = c_q[k*L + int'(phase_use)];
    end

    always_comb begin
        for (int lv = 0; lv <= LVL; lv++)
            for (int i = 0; i < TPP; i++)
                tree_d[lv][i] = '0;
        for (int k = 0; k < TPP; k++)
            tree_d[0][k] = AW'(coef_sel[k]) * AW'(xd_d[k]);
        for (int lv = 1; lv <= LVL; lv++)
            for (int i = 0; i < TPP; i++)
                if (2*i + 1 < node_cnt(lv - 1))
                    tree_d[lv][i] = tree_q[lv-1][2*i] + tree_q[lv-1][2*i+1];
                else if (2*i < node_cnt(lv - 1))
                    tree_d[lv][i] = tree_q[lv-1][2*i];
    end

    always_comb begin
        {sat_c, y_c} = sat_fn(round_fn(tree_q[LVL][0]));
        y_d   = vld_q[LVL] ? y_c : y_q;
        sat_d = vld_q[LVL] & sat_c;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < TAPS; i++) c_q[i] <= '0;
        end else if (coef_wr_en && int'(coef_wr_addr) < TAPS) begin
            c_q[coef_wr_addr] <= coef_wr_data;
        end
    end

    // Stage boundary: delay line and phase, product register, adder levels, output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < TPP; k++) xd_q[k] <= '0;
            for (int lv = 0; lv <= LVL; lv++)
                for (int i = 0; i < TPP; i++)
                    tree_q[lv][i] <= '0;
            phase_q   <= '0;
            vld_q     <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            xd_q      <= xd_d;
            tree_q    <= tree_d;
            phase_q   <= phase_d;
            vld_q     <= {vld_q[LVL-1+1-1:0], sam_clk_ena} >> 0;
            y_q       <= y_d;
            y_valid_q <= vld_q[LVL];
            sat_q     <= sat_d;
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign sat     = sat_q;

endmodule
